// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and defaults for the data-memory responder.
package mem_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;
    localparam logic [31:0] DEFAULT_BASE = 32'h1000_0000;
    localparam int MAX_LATENCY = 15;
endpackage

// File: rtl/data_word_ram.sv
// data_word_ram: word array with byte-enabled write and registered read (old data on collision).
module data_word_ram #(
    parameter int WORDS = 1024,
    localparam int AW = $clog2(WORDS)
) (
    output logic [31:0]   rdata,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    input  logic          we,
    input  logic          clk
);
    logic [31:0] mem [WORDS];
    always_ff @(posedge clk) begin
        rdata <= mem[index];
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder with programmable latency.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          WORDS   = 1024,
    parameter logic [31:0] BASE    = DEFAULT_BASE,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    state_t state, next;
    logic [3:0] cnt;
    logic wr_q, rd_ok;
    logic [31:0] addr_q, wdata_q, ram_rdata;
    logic [3:0] be_q;
    logic accept, commit, we, cur_write, cur_err;
    logic [31:0] cur_addr, cur_wdata, off;
    logic [3:0] cur_be;
    // With LATENCY==1 the commit happens on the accept edge, so the live request is used in IDLE.
    always_comb begin
        accept    = req_valid & req_ready;
        cur_write = state == S_IDLE ? req_write : wr_q;
        cur_addr  = state == S_IDLE ? req_addr  : addr_q;
        cur_wdata = state == S_IDLE ? req_wdata : wdata_q;
        cur_be    = state == S_IDLE ? req_be    : be_q;
        off       = cur_addr - BASE;
        cur_err   = (|cur_addr[1:0]) || (off[31:2] >= 30'(WORDS));
        next      = state == S_IDLE ? (accept ? (LATENCY == 1 ? S_RESP : S_BUSY) : S_IDLE) :
                    state == S_BUSY ? (cnt == 4'd1 ? S_RESP : S_BUSY) :
                    (resp_ready ? S_IDLE : S_RESP);
        commit    = state != S_RESP && next == S_RESP;
        we        = commit & reset & cur_write & ~cur_err;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_ok      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state      <= next;
            req_ready  <= next == S_IDLE;
            resp_valid <= next == S_RESP;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                cnt     <= CNT_INIT;
            end else if (state == S_BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_err <= cur_err;
                rd_ok    <= ~cur_write & ~cur_err;
            end else if (state == S_RESP && resp_ready) begin
                resp_err <= 1'b0;
                rd_ok    <= 1'b0;
            end
        end
    end
    // The RAM re-reads the latched word every cycle in RESP, so the load data stays stable.
    assign resp_rdata = rd_ok ? ram_rdata : 32'd0;
    data_word_ram #(.WORDS(WORDS)) u_ram (
        .rdata (ram_rdata),
        .index (off[AW+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .we    (we),
        .clk   (clk)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of two responders (LATENCY 2 and 3).
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst[2], v[2], wr[2], rr[2], rdy[2], rv[2], er[2];
    logic [31:0] a[2], wd[2], rd[2];
    logic [3:0] be[2];
    int n_chk = 0;
    int n_fail = 0;

    data_mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .reset(rst[0]), .req_valid(v[0]), .req_ready(rdy[0]), .req_write(wr[0]),
        .req_addr(a[0]), .req_wdata(wd[0]), .req_be(be[0]), .resp_valid(rv[0]),
        .resp_ready(rr[0]), .resp_rdata(rd[0]), .resp_err(er[0])
    );
    data_mem_responder #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(rst[1]), .req_valid(v[1]), .req_ready(rdy[1]), .req_write(wr[1]),
        .req_addr(a[1]), .req_wdata(wd[1]), .req_be(be[1]), .resp_valid(rv[1]),
        .resp_ready(rr[1]), .resp_rdata(rd[1]), .resp_err(er[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic w, input logic [31:0] ad, input logic [31:0] dat,
                        input logic [3:0] b, input string tag);
        @(negedge clk);
        chkb({tag, " req_ready"}, rdy[s], 1'b1);
        v[s] = 1'b1; wr[s] = w; a[s] = ad; wd[s] = dat; be[s] = b;
        @(posedge clk); #1;
        v[s] = 1'b0;
        chkb({tag, " no early resp_valid"}, rv[s], 1'b0);
    endtask

    task automatic wait_resp(input int s, input string tag);
        int lat = 0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rv[s]) begin lat = i; break; end
        end
        chk({tag, " latency"}, lat, (s == 1) ? 32'd3 : 32'd2);
    endtask

    task automatic finish_resp(input int s, input logic [31:0] exp_rd, input logic exp_err, input string tag);
        chk({tag, " rdata"}, rd[s], exp_rd);
        chkb({tag, " err"}, er[s], exp_err);
        @(negedge clk);
        rr[s] = 1'b1;
        @(posedge clk); #1;
        rr[s] = 1'b0;
        chkb({tag, " resp_valid drop"}, rv[s], 1'b0);
        chkb({tag, " back to idle"}, rdy[s], 1'b1);
    endtask

    task automatic access(input int s, input logic w, input logic [31:0] ad, input logic [31:0] dat,
                          input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err, input string tag);
        send(s, w, ad, dat, b, tag);
        wait_resp(s, tag);
        finish_resp(s, exp_rd, exp_err, tag);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b0; v[s] = 1'b0; wr[s] = 1'b0; rr[s] = 1'b0;
            a[s] = '0; wd[s] = '0; be[s] = '0;
        end
        @(posedge clk); @(posedge clk); #1;
        chkb("in reset req_ready", rdy[0], 1'b0);
        chkb("in reset resp_valid", rv[0], 1'b0);
        @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;
        @(posedge clk); #1;
        chkb("post reset req_ready", rdy[0], 1'b1);
        chkb("post reset resp_valid", rv[0], 1'b0);
        chkb("post reset resp_err", er[0], 1'b0);
        chk("post reset resp_rdata", rd[0], 32'd0);

        access(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, "store full");
        access(0, 1'b0, 32'h1000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, "load full");
        access(0, 1'b1, 32'h1000_0010, 32'h0000_00AA, 4'b0001, 32'd0, 1'b0, "store byte0");
        access(0, 1'b0, 32'h1000_0010, 32'd0, 4'h0, 32'hDEAD_BEAA, 1'b0, "load merged");
        access(0, 1'b1, 32'h1000_0000, 32'h1111_1111, 4'hF, 32'd0, 1'b0, "store word0");
        access(0, 1'b0, 32'h1000_0002, 32'd0, 4'h0, 32'd0, 1'b1, "load misaligned");
        access(0, 1'b0, 32'h1000_1000, 32'd0, 4'h0, 32'd0, 1'b1, "load past end");
        access(0, 1'b0, 32'h0FFF_FFFC, 32'd0, 4'h0, 32'd0, 1'b1, "load below base");
        access(0, 1'b1, 32'h1000_1000, 32'h1234_5678, 4'hF, 32'd0, 1'b1, "store past end");
        access(0, 1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0, "store be0");
        access(0, 1'b0, 32'h1000_0000, 32'd0, 4'h0, 32'h1111_1111, 1'b0, "word0 intact");

        send(0, 1'b0, 32'h1000_0010, 32'd0, 4'h0, "held load");
        wait_resp(0, "held load");
        v[0] = 1'b1; wr[0] = 1'b0; a[0] = 32'h1000_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chkb("hold resp_valid", rv[0], 1'b1);
            chk("hold rdata", rd[0], 32'hDEAD_BEAA);
            chkb("hold req_ready", rdy[0], 1'b0);
        end
        @(negedge clk);
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        chkb("handshake resp_valid", rv[0], 1'b0);
        chkb("handshake req_ready", rdy[0], 1'b1);
        @(posedge clk); #1;
        v[0] = 1'b0;
        chkb("next accepted", rdy[0], 1'b0);
        wait_resp(0, "next load");
        finish_resp(0, 32'h1111_1111, 1'b0, "next load");

        access(1, 1'b1, 32'h1000_0020, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, "l3 store");
        send(1, 1'b1, 32'h1000_0020, 32'h0BAD_BEEF, 4'hF, "l3 aborted store");
        @(negedge clk);
        rst[1] = 1'b0;
        @(posedge clk); #1;
        chkb("l3 reset req_ready", rdy[1], 1'b0);
        chkb("l3 reset resp_valid", rv[1], 1'b0);
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        chkb("l3 idle after reset", rdy[1], 1'b1);
        access(1, 1'b0, 32'h1000_0020, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, "l3 load prior");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
